uart_bits_rx: RTL and testbench
===============================

Name: uart_bits_rx

Overview:
UART receiver, the receive-side partner of UART_Bits_TX. Frame format: 1 start bit (0), DATA_BITS data bits sent LSB first, 1 stop bit (1). The block synchronises the asynchronous rx line and samples each bit at its centre. It delivers each received byte through a valid/ready holding register and flags framing errors and overruns. It sits between the chip's rx pad and the CPU-side UART register/FIFO logic.

Parameters:
DATA_BITS, 8, data bits per frame (≥2)
CLKS_PER_BIT, 1, clock cycles per bit; 1 matches UART_Bits_TX (one bit per clk)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx  input  1  serial line, asynchronous, idles high
data_out  output  DATA_BITS  received byte, stable while valid=1
valid  output  1  data_out holds an unconsumed byte
ready  input  1  consumer accepts data_out when valid&&ready at a rising edge
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
overrun  output  1  sticky: a completed byte was dropped because the holding register was full
clr_overrun  input  1  synchronous clear of overrun
busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, sync flops=1, data_out=0, valid=0, frame_err=0, overrun=0, bit_cnt=0, baud counter=0.
- rx passes through a 2-flop synchroniser; rx_s is the 2nd flop. All decisions use rx_s only.
- HALF = (CLKS_PER_BIT-1)/2. The baud counter counts down; a "tick" is counter==0.
- IDLE: when rx_s==0: if HALF==0, go to DATA with counter=CLKS_PER_BIT-1; otherwise go to START with counter=HALF-1.
- START: decrement the counter. At the tick: if rx_s==0 (start bit confirmed), go to DATA with counter=CLKS_PER_BIT-1. Otherwise the low was a glitch; go to IDLE with no flags.
- DATA: decrement the counter. At each tick: shift rx_s into the MSB of shift_reg (right shift, so LSB-first arrival ends aligned), reload counter=CLKS_PER_BIT-1, bit_cnt++. When the DATA_BITS-th bit is sampled, go to STOP and clear bit_cnt.
- STOP: at the tick:
  - rx_s==1: the byte completes; go to IDLE.
  - rx_s==0: pulse frame_err for one cycle, discard the byte, go to BREAK_WAIT.
- BREAK_WAIT: stay until rx_s==1, then go to IDLE. This prevents a held-low line from being re-detected as a start bit.
- Byte completion and the holding register:
  - valid==0, or valid&&ready in the same cycle: load data_out=shift_reg; valid stays/becomes 1.
  - valid&&!ready: keep the old data_out, set overrun=1, drop the new byte.
- Consumption: valid&&ready with no completion clears valid the next cycle.
- overrun: cleared by clr_overrun. If clr_overrun and a new overrun event occur in the same cycle, set wins.
- Latency (CLKS_PER_BIT=1): take E0 as the first rising edge at which rx=0 (start bit). Data bit k is on rx at E(k+1). valid is high after edge E(DATA_BITS+3), i.e. E11 for 8 bits. Back-to-back frames (the next start bit immediately after the stop bit) are received without loss.
- Reset mid-frame: abort immediately and discard the partial byte; no flags are raised after reset is released.

Decomposition:
- Shared package uart_pkg: rx state encoding (IDLE=0, START=1, DATA=2, STOP=3, BREAK_WAIT=4, 3 bits), idle line level constant, and a function computing HALF from CLKS_PER_BIT.
- Sub-module uart_rx_sync: 2-flop synchroniser with reset value 1 (same async active-low reset). The FSM, counters and holding register stay in uart_bits_rx.

Test Plan:
- CLKS_PER_BIT=1, drive frame for 0xA5 (0,1,0,1,0,0,1,0,1,1), ready=1 → valid high for 1 cycle after E11, data_out=0xA5, frame_err=0.
- Loopback: UART_Bits_TX.tx → rx, send 0x3C then 0xC3 back-to-back with ready=1 → two valid beats, data 0x3C then 0xC3, overrun=0.
- CLKS_PER_BIT=16:
  - rx low for 4 cycles then high → glitch rejected, returns to IDLE, no valid.
  - Full frame 0x5A → data_out=0x5A.
- Frame 0x00 with stop bit driven 0, rx held low 40 cycles then high → one frame_err pulse, no valid, no second start detected until after rx rises.
- ready=0, send 0x11 then 0x22 → data_out stays 0x11, overrun=1 at second completion. Pulse clr_overrun → overrun=0. Then ready=1 → valid drops next cycle.
- Assert reset during bit 4 of a frame, release, send 0x81 → only 0x81 delivered, no frame_err/overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_t  : receiver FSM state encoding (3 bits)
//   LINE_IDLE   : level of an idle serial line (mark)
//   half_period : number of extra clocks needed to move from the start
//                 bit's leading edge to its centre, given clocks per bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Offset from the detected falling edge to the bit centre.
    function automatic int half_period(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Two-flop synchroniser for the asynchronous rx pad. Both flops reset to
// the idle line level so that reset release never looks like a start bit.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   rx    : raw serial line from the pad
//   rx_s  : synchronised serial line (second flop)
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic rx_meta;

    // Plain two-stage synchroniser; rx_meta may go metastable and is only
    // ever read by the second stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= LINE_IDLE;
            rx_s    <= LINE_IDLE;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

endmodule

// File: rtl/uart_bits_rx.sv
// uart_bits_rx
// UART receiver: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit.
// Each bit is sampled at its centre using a down-counting baud counter.
// Received bytes are handed over through a valid/ready holding register.
// Ports:
//   clk         : system clock
//   reset       : asynchronous, active-low reset
//   rx          : serial line, asynchronous, idles high
//   data_out    : received byte, stable while valid is high
//   valid       : data_out holds an unconsumed byte
//   ready       : consumer accepts data_out when valid && ready at a clock edge
//   frame_err   : one-cycle pulse when the stop bit is sampled low
//   overrun     : sticky, a completed byte was dropped (holding register full)
//   clr_overrun : synchronous clear of overrun (a new overrun event wins)
//   busy        : receiver is not idle
module uart_bits_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 busy
);

    localparam int HALF  = half_period(CLKS_PER_BIT);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'((HALF > 0) ? (HALF - 1) : 0);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 tick;
    logic                 shift_en;
    logic                 byte_done;
    logic                 frame_bad;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s)
    );

    assign tick = (cnt == '0);
    assign busy = (state != IDLE);

    // State, baud counter and bit counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    // Next-state logic. With one clock per bit there is no room to wait for
    // the start bit centre, so the start bit is accepted on its first low
    // sample and the FSM goes straight to DATA. A low stop bit parks the FSM
    // in BREAK_WAIT until the line returns high, so a held-low line is not
    // mistaken for a stream of new start bits.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_cnt_next = bit_cnt;
        shift_en     = 1'b0;
        byte_done    = 1'b0;
        frame_bad    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_s != LINE_IDLE) begin
                    if (HALF == 0) begin
                        state_next = DATA;
                        cnt_next   = CNT_RELOAD;
                    end else begin
                        state_next = START;
                        cnt_next   = CNT_HALF;
                    end
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s != LINE_IDLE) begin
                        state_next = DATA;
                        cnt_next   = CNT_RELOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    cnt_next = CNT_RELOAD;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_next = '0;
                    if (rx_s == LINE_IDLE) begin
                        byte_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = BREAK_WAIT;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            BREAK_WAIT: begin
                if (rx_s == LINE_IDLE) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Data path: shift register, holding register, and status flags.
    // A completing byte may replace the held one only if the held byte is
    // being consumed in the same cycle; otherwise it is dropped and overrun
    // is raised. Setting overrun takes priority over clr_overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            end
            if (byte_done) begin
                if (!valid || ready) begin
                    data_out <= shift_reg;
                    valid    <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (byte_done && valid && !ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_bits_rx.sv
// tb_uart_bits_rx
// Bench for uart_bits_rx with two instances: one at one clock per bit and
// one at sixteen clocks per bit. Expected bytes are queued as frames are
// sent; monitors pop and compare them at every valid&&ready handshake.
module tb_uart_bits_rx;

    logic       clk = 1'b0;
    logic       reset;

    logic       rx1, ready1, clr1;
    logic [7:0] data1;
    logic       valid1, ferr1, ovr1, busy1;

    logic       rx16, ready16, clr16;
    logic [7:0] data16;
    logic       valid16, ferr16, ovr16, busy16;

    int         checks = 0;
    int         fails  = 0;
    int         ferr1_cycles  = 0;
    int         ferr16_cycles = 0;
    logic [7:0] q1[$];
    logic [7:0] q16[$];

    always #5 clk = ~clk;

    uart_bits_rx #(.DATA_BITS(8), .CLKS_PER_BIT(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx1),
        .data_out    (data1),
        .valid       (valid1),
        .ready       (ready1),
        .frame_err   (ferr1),
        .overrun     (ovr1),
        .clr_overrun (clr1),
        .busy        (busy1)
    );

    uart_bits_rx #(.DATA_BITS(8), .CLKS_PER_BIT(16)) dut16 (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx16),
        .data_out    (data16),
        .valid       (valid16),
        .ready       (ready16),
        .frame_err   (ferr16),
        .overrun     (ovr16),
        .clr_overrun (clr16),
        .busy        (busy16)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One frame at one bit per clock; called just after a rising edge.
    // The line is left at the stop level so frames can follow back-to-back.
    task automatic applyStimulus1(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx1 = f[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus16(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx16 = f[i];
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitors: compare on every handshake, count frame_err cycles.
    always @(negedge clk) begin
        if (reset) begin
            if (ferr1) ferr1_cycles++;
            if (valid1 && ready1) begin
                if (q1.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL rx1_unexpected_byte actual=%0h expected=none", data1);
                end else begin
                    checkOutput("rx1_byte", {24'h0, data1}, {24'h0, q1.pop_front()});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (ferr16) ferr16_cycles++;
            if (valid16 && ready16) begin
                if (q16.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL rx16_unexpected_byte actual=%0h expected=none", data16);
                end else begin
                    checkOutput("rx16_byte", {24'h0, data16}, {24'h0, q16.pop_front()});
                end
            end
        end
    end

    initial begin
        reset   = 1'b0;
        rx1     = 1'b1;
        rx16    = 1'b1;
        ready1  = 1'b1;
        ready16 = 1'b1;
        clr1    = 1'b0;
        clr16   = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        checkOutput("reset_valid1", {31'h0, valid1}, 32'h0);
        checkOutput("reset_data1",  {24'h0, data1},  32'h0);
        checkOutput("reset_ovr1",   {31'h0, ovr1},   32'h0);
        checkOutput("reset_ferr1",  {31'h0, ferr1},  32'h0);
        checkOutput("reset_busy1",  {31'h0, busy1},  32'h0);
        checkOutput("reset_valid16", {31'h0, valid16}, 32'h0);
        checkOutput("reset_busy16",  {31'h0, busy16},  32'h0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 0xA5 at one clock per bit: valid appears exactly after E11
        q1.push_back(8'hA5);
        applyStimulus1(8'hA5, 1'b1);
        @(posedge clk); #1;
        checkOutput("a5_valid_e10", {31'h0, valid1}, 32'h0);
        @(posedge clk); #1;
        checkOutput("a5_valid_e11", {31'h0, valid1}, 32'h1);
        checkOutput("a5_data_e11",  {24'h0, data1},  32'hA5);
        @(posedge clk); #1;
        checkOutput("a5_valid_e12", {31'h0, valid1}, 32'h0);
        checkOutput("a5_ferr", ferr1_cycles, 32'd0);

        // Back-to-back frames as a transmitter would send them
        repeat (3) @(posedge clk);
        #1;
        q1.push_back(8'h3C);
        q1.push_back(8'hC3);
        applyStimulus1(8'h3C, 1'b1);
        applyStimulus1(8'hC3, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("b2b_drained", q1.size(), 32'd0);
        checkOutput("b2b_overrun", {31'h0, ovr1}, 32'h0);

        // Short low glitch at sixteen clocks per bit is rejected
        rx16 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("glitch_busy", {31'h0, busy16}, 32'h1);
        rx16 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("glitch_idle", {31'h0, busy16}, 32'h0);

        // Full frame 0x5A at sixteen clocks per bit
        q16.push_back(8'h5A);
        applyStimulus16(8'h5A, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("x16_drained", q16.size(), 32'd0);
        checkOutput("x16_ferr", ferr16_cycles, 32'd0);

        // Stop bit low, line held low: one frame_err, no restart
        applyStimulus1(8'h00, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("break_busy", {31'h0, busy1}, 32'h1);
        checkOutput("break_ferr_once", ferr1_cycles, 32'd1);
        rx1 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("break_released", {31'h0, busy1}, 32'h0);
        checkOutput("break_ferr_after", ferr1_cycles, 32'd1);

        // Overrun: holding register full, second byte dropped
        ready1 = 1'b0;
        q1.push_back(8'h11);
        applyStimulus1(8'h11, 1'b1);
        applyStimulus1(8'h22, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("ovr_set",   {31'h0, ovr1},   32'h1);
        checkOutput("ovr_data",  {24'h0, data1},  32'h11);
        checkOutput("ovr_valid", {31'h0, valid1}, 32'h1);
        clr1 = 1'b1;
        @(posedge clk); #1;
        clr1 = 1'b0;
        checkOutput("ovr_cleared", {31'h0, ovr1}, 32'h0);
        ready1 = 1'b1;
        @(posedge clk); #1;
        checkOutput("ovr_valid_drop", {31'h0, valid1}, 32'h0);
        checkOutput("ovr_drained", q1.size(), 32'd0);

        // Reset during bit 4 of a frame, then a clean 0x81
        repeat (3) @(posedge clk);
        #1;
        rx1 = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            rx1 = i[0] ? 1'b0 : 1'b1;
            @(posedge clk); #1;
        end
        rx1 = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy",  {31'h0, busy1},  32'h0);
        checkOutput("midrst_valid", {31'h0, valid1}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        ferr1_cycles = 0;
        repeat (3) @(posedge clk);
        #1;
        q1.push_back(8'h81);
        applyStimulus1(8'h81, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midrst_drained", q1.size(), 32'd0);
        checkOutput("midrst_ferr", ferr1_cycles, 32'd0);
        checkOutput("midrst_ovr", {31'h0, ovr1}, 32'h0);
        checkOutput("final_ovr16", {31'h0, ovr16}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
